nn_layer_sequencer: RTL and testbench

- Time-multiplexes one shared combinational two-input neuron datapath (Q8.8 inputs, weights and bias; 1-bit step output) across N_NEURONS logical neurons of a layer.
- Holds per-neuron weights (cA, cB, bias) in a local register file and latches the layer inputs on start.
- Presents one neuron's operands per cycle to the shared datapath and collects the 1-bit outputs into a result vector.
- Sits between the layer input registers and the next layer, replacing N parallel neuron instances.

---
 rtl/nn_layer_sequencer_if.sv | 33 +++
 rtl/nn_layer_sequencer.sv | 169 ++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/nn_layer_sequencer_if.sv
// Bundle between the layer sequencer and its neighbours: control/weight-load side,
// status/result side, and the operand/output pair of the shared neuron datapath.
interface nn_layer_sequencer_if #(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = 2
);
  logic                 start;
  logic [15:0]          in_a;
  logic [15:0]          in_b;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic [1:0]           wr_sel;
  logic [15:0]          wr_data;
  logic                 busy;
  logic                 done;
  logic [N_NEURONS-1:0] result;
  logic [15:0]          nu_a;
  logic [15:0]          nu_b;
  logic [15:0]          nu_ca;
  logic [15:0]          nu_cb;
  logic [15:0]          nu_bias;
  logic                 nu_f;

  modport master (
    output start, in_a, in_b, wr_en, wr_idx, wr_sel, wr_data, nu_f,
    input  busy, done, result, nu_a, nu_b, nu_ca, nu_cb, nu_bias
  );

  modport slave (
    input  start, in_a, in_b, wr_en, wr_idx, wr_sel, wr_data, nu_f,
    output busy, done, result, nu_a, nu_b, nu_ca, nu_cb, nu_bias
  );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Time-multiplexes one shared two-input neuron datapath across N_NEURONS logical neurons.
// Optional macro NN_SEQ_PIPE_EN registers nu_f before capture and adds a DRAIN state.
module nn_layer_sequencer #(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  nn_layer_sequencer_if.slave  bus
);
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVAL  = 2'd1,
    S_DONE  = 2'd2
`ifdef NN_SEQ_PIPE_EN
    , S_DRAIN = 2'd3
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]    in_a_q, in_a_d, in_b_q, in_b_d;
  logic [DATA_W-1:0]    ca_q   [N_NEURONS];
  logic [DATA_W-1:0]    ca_d   [N_NEURONS];
  logic [DATA_W-1:0]    cb_q   [N_NEURONS];
  logic [DATA_W-1:0]    cb_d   [N_NEURONS];
  logic [DATA_W-1:0]    bias_q [N_NEURONS];
  logic [DATA_W-1:0]    bias_d [N_NEURONS];
  logic [N_NEURONS-1:0] result_q, result_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0]    nu_a_q, nu_a_d, nu_b_q, nu_b_d;
  logic [DATA_W-1:0]    nu_ca_q, nu_ca_d, nu_cb_q, nu_cb_d, nu_bias_q, nu_bias_d;
  logic                 wr_ok;
  logic                 last_idx;
`ifdef NN_SEQ_PIPE_EN
  logic                 f_q, f_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    in_a_d   = in_a_q;
    in_b_d   = in_b_q;
    ca_d     = ca_q;
    cb_d     = cb_q;
    bias_d   = bias_q;
    result_d = result_q;
`ifdef NN_SEQ_PIPE_EN
    f_d      = f_q;
`endif
    last_idx = (32'(idx_q) == N_NEURONS - 1);

    // Weights are only writable in IDLE, so a run always sees a frozen set.
    wr_ok = bus.wr_en && (state_q == S_IDLE) && (32'(bus.wr_idx) < N_NEURONS);
    if (wr_ok) begin
      case (bus.wr_sel)
        2'd0:    ca_d[bus.wr_idx]   = bus.wr_data;
        2'd1:    cb_d[bus.wr_idx]   = bus.wr_data;
        2'd2:    bias_d[bus.wr_idx] = bus.wr_data;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_EVAL;
          idx_d   = '0;
          in_a_d  = bus.in_a;
          in_b_d  = bus.in_b;
        end
      end
      S_EVAL: begin
`ifdef NN_SEQ_PIPE_EN
        f_d = bus.nu_f;
        if (idx_q != '0) result_d[idx_q - IDX_W'(1)] = f_q;
        if (last_idx) state_d = S_DRAIN;
        else          idx_d   = idx_q + IDX_W'(1);
`else
        result_d[idx_q] = bus.nu_f;
        if (last_idx) state_d = S_DONE;
        else          idx_d   = idx_q + IDX_W'(1);
`endif
      end
`ifdef NN_SEQ_PIPE_EN
      S_DRAIN: begin
        result_d[N_NEURONS-1] = f_q;
        state_d               = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-cycle state and
    // the post-write weights (a write coinciding with start is seen by neuron 0).
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    if (state_d == S_EVAL) begin
      nu_a_d    = in_a_d;
      nu_b_d    = in_b_d;
      nu_ca_d   = ca_d[idx_d];
      nu_cb_d   = cb_d[idx_d];
      nu_bias_d = bias_d[idx_d];
    end else begin
      nu_a_d    = '0;
      nu_b_d    = '0;
      nu_ca_d   = '0;
      nu_cb_d   = '0;
      nu_bias_d = '0;
    end
  end

  // Register stage: every state, weight, latched input and output flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      in_a_q    <= '0;
      in_b_q    <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        ca_q[i]   <= '0;
        cb_q[i]   <= '0;
        bias_q[i] <= '0;
      end
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nu_a_q    <= '0;
      nu_b_q    <= '0;
      nu_ca_q   <= '0;
      nu_cb_q   <= '0;
      nu_bias_q <= '0;
`ifdef NN_SEQ_PIPE_EN
      f_q       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      in_a_q    <= in_a_d;
      in_b_q    <= in_b_d;
      ca_q      <= ca_d;
      cb_q      <= cb_d;
      bias_q    <= bias_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nu_a_q    <= nu_a_d;
      nu_b_q    <= nu_b_d;
      nu_ca_q   <= nu_ca_d;
      nu_cb_q   <= nu_cb_d;
      nu_bias_q <= nu_bias_d;
`ifdef NN_SEQ_PIPE_EN
      f_q       <= f_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.nu_a    = nu_a_q;
  assign bus.nu_b    = nu_b_q;
  assign bus.nu_ca   = nu_ca_q;
  assign bus.nu_cb   = nu_cb_q;
  assign bus.nu_bias = nu_bias_q;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench for nn_layer_sequencer: scripted scenarios plus randomized
// weight/input runs checked against an array-based reference of the layer.
module tb_nn_layer_sequencer;
  localparam int N     = 4;
  localparam int IDX_W = 2;
`ifdef NN_SEQ_PIPE_EN
  localparam int DONE_CYC = N + 2;
`else
  localparam int DONE_CYC = N + 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [15:0] mca [N];
  logic [15:0] mcb [N];
  logic [15:0] mbs [N];

  nn_layer_sequencer_if #(.N_NEURONS(N), .IDX_W(IDX_W)) bus ();

  nn_layer_sequencer #(.N_NEURONS(N), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic bit neuron(input logic [15:0] a, b, ca, cb, bs);
    longint s;
    s = (longint'($signed(a)) * longint'($signed(ca)) +
         longint'($signed(b)) * longint'($signed(cb))) >>> 8;
    s = s + longint'($signed(bs));
    return s > 0;
  endfunction

  // Stand-in for the shared combinational neuron datapath.
  assign bus.nu_f = neuron(bus.nu_a, bus.nu_b, bus.nu_ca, bus.nu_cb, bus.nu_bias);

  function automatic logic [N-1:0] model_layer(input logic [15:0] a, b);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = neuron(a, b, mca[k], mcb[k], mbs[k]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input int idx, input int sel, input logic [15:0] d);
    if (idx < N) begin
      if (sel == 0) mca[idx] = d;
      else if (sel == 1) mcb[idx] = d;
      else if (sel == 2) mbs[idx] = d;
    end
  endtask

  task automatic wr(input int idx, input int sel, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_idx  = IDX_W'(idx);
    bus.wr_sel  = 2'(sel);
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    model_write(idx, sel, d);
  endtask

  // One layer run; smask/wmask bit c injects start / an n1-bias write in cycle c.
  task automatic run(input string nm, input logic [15:0] a, b, input logic [N-1:0] exp_res,
                     input int smask, input int wmask);
    bus.in_a  = a;
    bus.in_b  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    bus.in_a  = 16'($urandom);
    bus.in_b  = 16'($urandom);
    for (int c = 1; c <= DONE_CYC + 2; c++) begin
      if (c <= N) begin
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.nu_a !== a || bus.nu_b !== b || bus.nu_ca !== mca[c-1] ||
            bus.nu_cb !== mcb[c-1] || bus.nu_bias !== mbs[c-1]) begin
          n_fail++;
          $display("FAIL %s operands cyc%0d: got busy=%b a=%h b=%h ca=%h cb=%h bias=%h want busy=1 a=%h b=%h ca=%h cb=%h bias=%h",
                   nm, c, bus.busy, bus.nu_a, bus.nu_b, bus.nu_ca, bus.nu_cb, bus.nu_bias,
                   a, b, mca[c-1], mcb[c-1], mbs[c-1]);
        end
      end
      n_cmp++;
      if (bus.done !== (c == DONE_CYC)) begin
        n_fail++;
        $display("FAIL %s done cyc%0d: got %b want %b", nm, c, bus.done, (c == DONE_CYC));
      end
      if (c == DONE_CYC) begin
        n_cmp++;
        if (bus.result !== exp_res || bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s result: got %h busy=%b want %h busy=1", nm, bus.result, bus.busy, exp_res);
        end
      end
      if (c > DONE_CYC) begin
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.nu_ca !== 16'h0 || bus.result !== exp_res) begin
          n_fail++;
          $display("FAIL %s idle cyc%0d: got busy=%b nu_ca=%h result=%h want busy=0 nu_ca=0 result=%h",
                   nm, c, bus.busy, bus.nu_ca, bus.result, exp_res);
        end
      end
      bus.start = smask[c];
      bus.wr_en = wmask[c];
      if (wmask[c]) begin
        bus.wr_idx  = IDX_W'(1);
        bus.wr_sel  = 2'd2;
        bus.wr_data = 16'h0200;
      end
      tick();
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_status: got busy=%b done=%b result=%h want 0 0 0", bus.busy, bus.done, bus.result);
    end
    n_cmp++;
    if ({bus.nu_a, bus.nu_b, bus.nu_ca, bus.nu_cb, bus.nu_bias} !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_operands: got %h %h %h %h %h want all 0",
               bus.nu_a, bus.nu_b, bus.nu_ca, bus.nu_cb, bus.nu_bias);
    end
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      mca[k] = '0; mcb[k] = '0; mbs[k] = '0;
    end
  endtask

  task automatic load_scenario_weights();
    wr(0, 0, 16'h0100); wr(0, 1, 16'h0100); wr(0, 2, 16'h0000);
    wr(1, 0, 16'h0100); wr(1, 1, 16'hFF00); wr(1, 2, 16'hFF00);
    wr(2, 0, 16'hFF00); wr(2, 1, 16'hFF00); wr(2, 2, 16'h0200);
    wr(3, 0, 16'h0000); wr(3, 1, 16'h0200); wr(3, 2, 16'hFF80);
  endtask

  task automatic test_full_run();
    load_scenario_weights();
    wr(2, 3, 16'h7777);
    run("full_run", 16'h0100, 16'h0080, 4'hD, 0, 0);
  endtask

  task automatic test_ignored_start();
    run("ignored_start", 16'h0100, 16'h0080, 4'hD, (1 << 2) | (1 << DONE_CYC), 0);
  endtask

  task automatic test_write_busy();
    run("write_busy", 16'h0100, 16'h0080, 4'hD, 0, (1 << 3));
    wr(1, 2, 16'h0200);
    run("write_idle", 16'h0100, 16'h0080, 4'hF, 0, 0);
  endtask

  task automatic test_mid_reset();
    bus.in_a  = 16'h0100;
    bus.in_b  = 16'h0080;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 4'h0 || bus.nu_ca !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got busy=%b done=%b result=%h nu_ca=%h want 0 0 0 0",
               bus.busy, bus.done, bus.result, bus.nu_ca);
    end
    for (int c = 0; c < DONE_CYC; c++) begin
      n_cmp++;
      if (bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_done cyc%0d: got %b want 0", c, bus.done);
      end
      tick();
    end
    for (int k = 0; k < N; k++) begin
      mca[k] = '0; mcb[k] = '0; mbs[k] = '0;
    end
    run("after_reset", 16'h0100, 16'h0080, 4'h0, 0, 0);
  endtask

  task automatic test_random();
    logic [15:0] a, b, d;
    int          idx, sel;
    for (int it = 0; it < 10; it++) begin
      for (int w = 0; w < 6; w++) wr(int'($urandom_range(0, N-1)), int'($urandom_range(0, 3)), 16'($urandom));
      a   = 16'($urandom);
      b   = 16'($urandom);
      idx = int'($urandom_range(0, N-1));
      sel = int'($urandom_range(0, 3));
      d   = 16'($urandom);
      // Write presented together with start commits and is used by this run.
      bus.wr_en   = 1'b1;
      bus.wr_idx  = IDX_W'(idx);
      bus.wr_sel  = 2'(sel);
      bus.wr_data = d;
      model_write(idx, sel, d);
      run("random", a, b, model_layer(a, b), 0, 0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.in_a    = '0;
    bus.in_b    = '0;
    bus.wr_en   = 1'b0;
    bus.wr_idx  = '0;
    bus.wr_sel  = '0;
    bus.wr_data = '0;
    test_reset();
    test_full_run();
    test_ignored_start();
    test_write_busy();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
